// File: rtl/md_pkg.sv
// Shared definitions for the md_lsu load/store unit: op codes, FSM states, lane widths
// and small decode helpers used by the FSM and the lane aligner.
package md_pkg;

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned HALF_W = 16;

  typedef enum logic [1:0] {
    StIdle,
    StRd,
    StWr,
    StRsp
  } state_e;

  function automatic logic is_store(input logic [2:0] op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

  // Clears the address bits below the access size.
  function automatic logic [1:0] force_align(input logic [2:0] op, input logic [1:0] lo);
    case (op)
      OP_LW, OP_SW:         return 2'b00;
      OP_LH, OP_LHU, OP_SH: return {lo[1], 1'b0};
      default:              return lo;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] lo);
    case (op)
      OP_LW, OP_SW:         return lo != 2'b00;
      OP_LH, OP_LHU, OP_SH: return lo[0];
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/md_lane_align.sv
// Combinational byte-lane logic: merges store data into the buffered word and
// extracts/extends load data from the memory word (little-endian lanes).
module md_lane_align
  import md_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  lane,
  input  logic [31:0] rbuf,
  input  logic [31:0] rword,
  input  logic [31:0] wdata,
  output logic [31:0] merged,
  output logic [31:0] extended
);

  logic [4:0]        bsh;
  logic [4:0]        hsh;
  logic [BYTE_W-1:0] bval;
  logic [HALF_W-1:0] hval;

  always_comb begin
    bsh    = {lane, 3'b000};
    hsh    = {lane[1], 4'b0000};
    bval   = rword[bsh +: BYTE_W];
    hval   = rword[hsh +: HALF_W];
    merged = rbuf;
    case (op)
      OP_SW:   merged = wdata;
      OP_SH:   merged[hsh +: HALF_W] = wdata[HALF_W-1:0];
      OP_SB:   merged[bsh +: BYTE_W] = wdata[BYTE_W-1:0];
      default: merged = rbuf;
    endcase

    case (op)
      OP_LB:   extended = {{(32 - BYTE_W){bval[BYTE_W-1]}}, bval};
      OP_LBU:  extended = {{(32 - BYTE_W){1'b0}}, bval};
      OP_LH:   extended = {{(32 - HALF_W){hval[HALF_W-1]}}, hval};
      OP_LHU:  extended = {{(32 - HALF_W){1'b0}}, hval};
      default: extended = rword;
    endcase
  end

endmodule

// File: rtl/md_lsu.sv
// Load/store initiator between CPU and word-addressed data memory (IDLE/RD/WR/RSP FSM).
// Define MD_LSU_MISALIGN_TRAP_EN to report misaligned accesses via err instead of aligning.
module md_lsu
  import md_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 32,
  parameter int unsigned AW        = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic [2:0]    op,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic          ready,
  output logic          done,
  output logic [31:0]   rdata,
  output logic          err,
  output logic [AW-1:0] AM,
  output logic [31:0]   DM_,
  output logic          EW,
  input  logic [31:0]   DM
);

  localparam logic [AW-1:0] MemWordsW = AW'(MEM_WORDS);

  state_e        state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rbuf_q, rbuf_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic [31:0]   merged;
  logic [31:0]   ext_word;

  md_lane_align u_align (
    .op       (op_q),
    .lane     (addr_q[1:0]),
    .rbuf     (rbuf_q),
    .rword    (DM),
    .wdata    (wdata_q),
    .merged   (merged),
    .extended (ext_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= OP_LW;
      addr_q  <= '0;
      wdata_q <= '0;
      rbuf_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rbuf_q  <= rbuf_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rbuf_d  = rbuf_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          op_d    = op;
          wdata_d = wdata;
          addr_d  = {addr[AW-1:2], force_align(op, addr[1:0])};
          err_d   = 1'b0;
`ifdef MD_LSU_MISALIGN_TRAP_EN
          if (is_misaligned(op, addr[1:0])) begin
            state_d = StRsp;
            err_d   = 1'b1;
            rdata_d = '0;
          end else if (op == OP_SW) begin
            state_d = StWr;
          end else begin
            state_d = StRd;
          end
`else
          if (op == OP_SW) begin
            state_d = StWr;
          end else begin
            state_d = StRd;
          end
`endif
        end
      end
      StRd: begin
        rbuf_d = DM;
        if (is_store(op_q)) begin
          state_d = StWr;
        end else begin
          rdata_d = ext_word;
          state_d = StRsp;
        end
      end
      StWr:    state_d = StRsp;
      StRsp:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign ready = (state_q == StIdle);
  assign done  = (state_q == StRsp);
  assign EW    = (state_q == StWr);
  assign DM_   = EW ? merged : '0;
  assign rdata = rdata_q;
  assign err   = err_q;
  // Word index wraps silently over the memory depth.
  assign AM    = {2'b00, addr_q[AW-1:2]} % MemWordsW;

endmodule

// File: tb/tb_md_lsu.sv
// Self-checking bench for md_lsu: directed scenarios plus random ops against a
// word-array reference model; honours MD_LSU_MISALIGN_TRAP_EN when defined.
module tb_md_lsu;
  import md_pkg::*;

  localparam int unsigned MEM_WORDS = 32;
  localparam int unsigned AW        = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          req;
  logic [2:0]    op;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic          ready;
  logic          done;
  logic [31:0]   rdata;
  logic          err;
  logic [AW-1:0] am;
  logic [31:0]   dm_w;
  logic          ew;
  logic [31:0]   dm_r;

  logic [31:0] dut_mem [MEM_WORDS];
  logic [31:0] ref_mem [MEM_WORDS];

  int n_cmp = 0;
  int n_bad = 0;
  int ew_cnt = 0;
  int ew_consec = 0;
  int done_cnt = 0;
  logic ew_prev = 1'b0;
  logic [31:0] last_dm = '0;

  md_lsu #(
    .MEM_WORDS (MEM_WORDS),
    .AW        (AW)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .op    (op),
    .addr  (addr),
    .wdata (wdata),
    .ready (ready),
    .done  (done),
    .rdata (rdata),
    .err   (err),
    .AM    (am),
    .DM_   (dm_w),
    .EW    (ew),
    .DM    (dm_r)
  );

  always #5 clk = ~clk;

  assign dm_r = dut_mem[am[4:0]];

  // Memory writes on the falling edge; monitor EW/done at the same point.
  always @(negedge clk) begin
    if (ew) begin
      dut_mem[am[4:0]] <= dm_w;
      ew_cnt++;
      last_dm = dm_w;
    end
    if (ew && ew_prev) ew_consec++;
    ew_prev = ew;
    if (done) done_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: applies one access to ref_mem and predicts its visible results.
  task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic e, output int lat,
                       output int nwr, output logic [31:0] nword);
    int w;
    int b;
    logic [31:0] word;
    logic [31:0] v;
    logic mis;
    w = int'((a >> 2) % MEM_WORDS);
    b = int'(a % 4);
    mis = ((o == OP_LW || o == OP_SW) && b != 0) ||
          ((o == OP_LH || o == OP_LHU || o == OP_SH) && (b % 2) == 1);
    rd = '0;
    e = 1'b0;
    nwr = 0;
    nword = ref_mem[w];
`ifdef MD_LSU_MISALIGN_TRAP_EN
    if (mis) begin
      e = 1'b1;
      lat = 1;
      return;
    end
`else
    if (mis) b = (o == OP_LW || o == OP_SW) ? 0 : (b / 2) * 2;
`endif
    word = ref_mem[w];
    lat = (o == OP_SH || o == OP_SB) ? 3 : 2;
    case (o)
      OP_LW:  rd = word;
      OP_LH, OP_LHU: begin
        v = (word >> (8 * b)) & 32'hFFFF;
        rd = (o == OP_LH && v >= 32'h8000) ? (v | 32'hFFFF_0000) : v;
      end
      OP_LB, OP_LBU: begin
        v = (word >> (8 * b)) & 32'hFF;
        rd = (o == OP_LB && v >= 32'h80) ? (v | 32'hFFFF_FF00) : v;
      end
      OP_SW: nword = wd;
      OP_SH: nword = (word & ~(32'hFFFF << (8 * b))) | ((wd & 32'hFFFF) << (8 * b));
      default: nword = (word & ~(32'hFF << (8 * b))) | ((wd & 32'hFF) << (8 * b));
    endcase
    if (o >= OP_SW) begin
      nwr = 1;
      ref_mem[w] = nword;
    end
  endtask

  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] wd,
                       input string tag);
    logic [31:0] erd;
    logic [31:0] enw;
    logic ee;
    int elat;
    int enwr;
    int lat;
    int ew0;
    model(o, a, wd, erd, ee, elat, enwr, enw);
    ew0 = ew_cnt;
    req = 1'b1;
    op = o;
    addr = a;
    wdata = wd;
    tick();
    req = 1'b0;
    lat = 1;
    while (!done && lat < 8) begin
      tick();
      lat++;
    end
    check({tag, ".lat"}, 32'(lat), 32'(elat));
    check({tag, ".err"}, 32'(err), 32'(ee));
    if (o < OP_SW || ee) check({tag, ".rdata"}, rdata, erd);
    tick();
    check({tag, ".ew"}, 32'(ew_cnt - ew0), 32'(enwr));
    if (enwr == 1) check({tag, ".dm"}, last_dm, enw);
  endtask

  initial begin
    int busy;
    int acc;
    int d0;
    int ew0;
    logic pend_load;
    logic [31:0] pend_rd;
    logic [31:0] erd;
    logic [31:0] enw;
    logic ee;
    int elat;
    int enwr;
    logic [2:0] o;
    logic [31:0] a;
    logic [31:0] wd;

    rst = 1'b1;
    req = 1'b0;
    op = '0;
    addr = '0;
    wdata = '0;
    for (int i = 0; i < int'(MEM_WORDS); i++) begin
      dut_mem[i] = '0;
      ref_mem[i] = '0;
    end
    dut_mem[3] = 32'h1122_3344;
    ref_mem[3] = 32'h1122_3344;
    tick();
    tick();
    check("rst.ready", 32'(ready), 32'd1);
    check("rst.done", 32'(done), 32'd0);
    check("rst.rdata", rdata, 32'd0);
    check("rst.err", 32'(err), 32'd0);
    check("rst.am", am, 32'd0);
    check("rst.dm", dm_w, 32'd0);
    check("rst.ew", 32'(ew), 32'd0);
    rst = 1'b0;
    tick();

    do_op(OP_LW, 32'h0C, 32'h0, "lw0c");
    do_op(OP_SB, 32'h0D, 32'hAA, "sb0d");
    do_op(OP_LBU, 32'h0D, 32'h0, "lbu0d");
    do_op(OP_LB, 32'h0D, 32'h0, "lb0d");
    do_op(OP_SH, 32'h12, 32'h8001, "sh12");
    check("sh12.mem4", dut_mem[4], 32'h8001_0000);
    do_op(OP_LH, 32'h12, 32'h0, "lh12");
    do_op(OP_LHU, 32'h12, 32'h0, "lhu12");

    // req held high with alternating SW/LW: only IDLE-presented requests are taken.
    busy = 0;
    acc = 0;
    pend_load = 1'b0;
    pend_rd = '0;
    d0 = done_cnt;
    for (int i = 0; i < 15; i++) begin
      o = (i % 2 == 1) ? OP_LW : OP_SW;
      a = 32'h40 + 32'(4 * (i % 4));
      wd = $urandom;
      req = 1'b1;
      op = o;
      addr = a;
      wdata = wd;
      check("hold.ready", 32'(ready), 32'(busy == 0));
      check("hold.done", 32'(done), 32'(busy == 1));
      if (busy == 1 && pend_load) check("hold.rdata", rdata, pend_rd);
      if (busy == 0) begin
        model(o, a, wd, erd, ee, elat, enwr, enw);
        pend_load = (o == OP_LW);
        pend_rd = erd;
        acc++;
        busy = 2;
      end else begin
        busy--;
      end
      tick();
    end
    req = 1'b0;
    repeat (4) tick();
    check("hold.ndone", 32'(done_cnt - d0), 32'(acc));

    // Reset during the RD cycle of an SB aborts it without a write.
    ew0 = ew_cnt;
    d0 = done_cnt;
    req = 1'b1;
    op = OP_SB;
    addr = 32'h0D;
    wdata = 32'h55;
    tick();
    req = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstrd.ready", 32'(ready), 32'd1);
    repeat (3) tick();
    check("rstrd.ew", 32'(ew_cnt - ew0), 32'd0);
    check("rstrd.done", 32'(done_cnt - d0), 32'd0);
    check("rstrd.mem3", dut_mem[3], ref_mem[3]);

    do_op(OP_LW, 32'h0E, 32'h0, "lw0e");
    do_op(OP_SH, 32'h13, 32'hBEEF, "sh13");
    do_op(OP_LHU, 32'h11, 32'h0, "lhu11");

    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      a = (i % 5 == 0) ? $urandom : 32'($urandom_range(0, 255));
      do_op(o, a, $urandom, "rand");
    end

    check("ew.consec", 32'(ew_consec), 32'd0);
    for (int i = 0; i < int'(MEM_WORDS); i++) begin
      check("final.mem", dut_mem[i], ref_mem[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
